alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters.
  - Requester 0: main execute path.
  - Requester 1: auxiliary unit, e.g. address-gen or debug.
- Round-robin arbitration, valid/ready request handshake per requester, registered operands, registered result.
- Drives the ALU's operand/control inputs and samples its result/zero outputs; the ALU sits outside this block.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CTRL_WIDTH, 4, ALU operation code width.
- MAX_OP, 4'b1001, highest legal ALU op code (XOR); codes above it are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op1  in  DATA_WIDTH  requester 0 operand1.
- req0_op2  in  DATA_WIDTH  requester 0 operand2.
- req0_ctrl  in  CTRL_WIDTH  requester 0 ALU op code.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl: same as above, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 consumes result.
- rsp_result  out  DATA_WIDTH  registered ALU result, shared by both responses.
- rsp_zero  out  1  registered ALU zero flag.
- rsp_err  out  1  illegal op code flag; see Optional Feature.
- alu_operand1  out  DATA_WIDTH  to ALU operand1.
- alu_operand2  out  DATA_WIDTH  to ALU operand2.
- alu_control  out  CTRL_WIDTH  to ALU alu_control.
- alu_result  in  DATA_WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - State IDLE; rr_ptr=0 (requester 0 has priority).
  - All outputs 0: ready, rsp valids, rsp_result, rsp_zero, rsp_err, alu_operand1/2, alu_control.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, only for the granted requester, at most one per cycle.
  - Grant rule: if only one valid, grant it; if both valid, grant rr_ptr; if none, stay IDLE.
  - On grant (valid&&ready): capture op1/op2/ctrl into operand registers, record owner, set rr_ptr = ~owner, go EXEC.
- EXEC (one cycle):
  - alu_operand1/2/alu_control are driven from the operand registers.
  - At cycle end, capture alu_result into rsp_result and alu_zero into rsp_zero; go RESP.
- RESP:
  - rspN_valid=1 for the owner only.
  - rsp_result/zero/err held stable until rspN_ready.
  - On ready, valid drops next cycle and state returns to IDLE.
  - No new grant in the handshake cycle; the earliest next accept is the cycle after.
- Latency: accept in cycle N -> rsp valid in cycle N+2. Minimum issue interval 3 cycles.
- alu_* outputs hold the last captured operands outside EXEC; no toggling while idle.
- rr_ptr changes only on a grant. A single repeated requester is never starved by an absent other.
- Request inputs are ignored outside IDLE. Requesters must hold valid and payload until ready.
- rsp_ready for the non-owner, or while not in RESP, has no effect.
- Reset mid-operation (EXEC or RESP): the pending result is discarded with no response; the block returns to reset values next cycle.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - At grant, ctrl > MAX_OP is flagged illegal.
  - EXEC still runs, but alu_control is driven 0 (AND) so the ALU never sees an undefined code.
  - In RESP: rsp_result=0, rsp_zero=1, rsp_err=1.
  - Legal ops: rsp_err=0.
- Not defined:
  - rsp_err is constant 0 and ctrl is passed through unchecked.
  - The result is whatever the ALU returns (X in simulation for undefined codes).

Test Plan:
- Single request: req0 op1=5, op2=3, ctrl=0010, rsp0_ready=1 -> req0_ready at cycle N; rsp0_valid at N+2, rsp_result=8, rsp_zero=0; rsp1_valid stays 0.
- Contention:
  - Stimulus: both valid continuously; req0=SUB(7,7); req1=XOR(0xF0,0x0F); rsp readies=1.
  - Response: grant order 0,1,0,1; rsp0 result=0, zero=1; rsp1 result=0xFF.
- Backpressure: rsp1_ready=0 for 4 cycles after rsp1_valid -> result held stable, req0_ready stays 0 despite req0_valid; rsp1_ready=1 -> IDLE, req0 granted next cycle.
- Shift/compare: req1 SRA op1=0x80000000, op2=4 -> 0xF8000000; SLTU op1=1, op2=0xFFFFFFFF -> 1.
- Reset in EXEC: rst=1 one cycle during EXEC -> no rsp valid ever for that op; all outputs 0; next req1 granted before simultaneous req0? No — rr_ptr=0, so req0 wins.
- With ALU_ARB_OPCHECK_EN: ctrl=4'b1111, op1=3, op2=4 -> alu_control=0 in EXEC; rsp_result=0, rsp_zero=1, rsp_err=1. Without the macro, rsp_err=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters with round-robin arbitration, registered operands and a
// registered result.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/ready          request handshake (ready is combinational)
//   req{0,1}_op1/op2/ctrl         request payload
//   rsp{0,1}_valid/ready          response handshake, owner only
//   rsp_result/zero/err           registered response payload (shared)
//   alu_operand1/2, alu_control   drive the external ALU
//   alu_result, alu_zero          sampled from the external ALU
//
// Build option
//   ALU_ARB_OPCHECK_EN  when defined, op codes above MAX_OP are flagged as
//                       illegal: the ALU sees code 0 and the response is
//                       result=0, zero=1, err=1. Otherwise rsp_err is 0.
module alu_share_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CTRL_WIDTH = 4,
   parameter logic [CTRL_WIDTH-1:0] MAX_OP = CTRL_WIDTH'(9)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_op1,
   input  logic [DATA_WIDTH-1:0] req0_op2,
   input  logic [CTRL_WIDTH-1:0] req0_ctrl,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_op1,
   input  logic [DATA_WIDTH-1:0] req1_op2,
   input  logic [CTRL_WIDTH-1:0] req1_ctrl,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] alu_operand1,
   output logic [DATA_WIDTH-1:0] alu_operand2,
   output logic [CTRL_WIDTH-1:0] alu_control,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero
);

`ifdef ALU_ARB_OPCHECK_EN
   localparam bit OPCHECK_EN = 1'b1;
`else
   localparam bit OPCHECK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                state;
   logic                  rr_ptr;
   logic                  owner;
   logic                  illegal;
   logic                  grant0;
   logic                  grant1;
   logic                  sel_illegal;
   logic [DATA_WIDTH-1:0] sel_op1;
   logic [DATA_WIDTH-1:0] sel_op2;
   logic [CTRL_WIDTH-1:0] sel_ctrl;

   // Grant: a lone valid wins, otherwise rr_ptr decides; only in IDLE.
   assign grant0 = (state == IDLE) && !rst && req0_valid && (!req1_valid || !rr_ptr);
   assign grant1 = (state == IDLE) && !rst && req1_valid && (!req0_valid || rr_ptr);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Payload of the granted requester.
   assign sel_op1     = grant1 ? req1_op1  : req0_op1;
   assign sel_op2     = grant1 ? req1_op2  : req0_op2;
   assign sel_ctrl    = grant1 ? req1_ctrl : req0_ctrl;
   assign sel_illegal = OPCHECK_EN && (sel_ctrl > MAX_OP);

   // Arbiter FSM; the ALU drive registers double as the operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= 1'b0;
         owner        <= 1'b0;
         illegal      <= 1'b0;
         rsp0_valid   <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_err      <= 1'b0;
         alu_operand1 <= '0;
         alu_operand2 <= '0;
         alu_control  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  owner        <= grant1;
                  rr_ptr       <= !grant1;
                  alu_operand1 <= sel_op1;
                  alu_operand2 <= sel_op2;
                  alu_control  <= sel_illegal ? '0 : sel_ctrl;
                  illegal      <= sel_illegal;
                  state        <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= illegal ? '0 : alu_result;
               rsp_zero   <= illegal ? 1'b1 : alu_zero;
               rsp_err    <= illegal;
               rsp0_valid <= !owner;
               rsp1_valid <= owner;
               state      <= RESP;
            end
            RESP: begin
               // Only the owner's ready completes the response.
               if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

`ifdef ALU_ARB_OPCHECK_EN
   localparam bit OPCHECK = 1'b1;
`else
   localparam bit OPCHECK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err;
   logic [31:0] alu_operand1, alu_operand2, alu_result;
   logic [3:0]  alu_control;
   logic        alu_zero;

   int tests = 0;
   int fails = 0;
   bit model_rr = 1'b0;

   always #5 clk = ~clk;

   // Reference ALU: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA, 6 SUB,
   // 7 SLT, 8 SLTU, 9 XOR; anything else returns 0.
   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a << b[4:0];
         4'd4: return a >> b[4:0];
         4'd5: return 32'($signed(a) >>> b[4:0]);
         4'd6: return a - b;
         4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8: return (a < b) ? 32'd1 : 32'd0;
         4'd9: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_control, alu_operand1, alu_operand2);
   assign alu_zero   = (alu_result == 32'd0);

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
      .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction from the IDLE cycle up to the response handshake.
   // Valids stay held throughout so the non-owner keeps requesting.
   task automatic transact(input bit v0, input bit v1,
                           input logic [3:0] c0, input logic [3:0] c1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input int hold);
      bit          own;
      bit          ill;
      logic [3:0]  c;
      logic [31:0] a, b, exp_r;
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = v0; req0_ctrl = c0; req0_op1 = a0; req0_op2 = b0;
      req1_valid = v1; req1_ctrl = c1; req1_op1 = a1; req1_op2 = b1;
      #1;
      check("idle_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("idle_rsp1_valid", 32'(rsp1_valid), 32'd0);
      if (!v0 && !v1) begin
         check("none_ready0", 32'(req0_ready), 32'd0);
         check("none_ready1", 32'(req1_ready), 32'd0);
         return;
      end
      own = (v0 && v1) ? model_rr : v1;
      check("grant_ready0", 32'(req0_ready), 32'(!own));
      check("grant_ready1", 32'(req1_ready), 32'(own));
      model_rr = !own;
      c = own ? c1 : c0;
      a = own ? a1 : a0;
      b = own ? b1 : b0;
      ill = OPCHECK && (c > 4'd9);
      exp_r = ill ? 32'd0 : alu_fn(c, a, b);
      // EXEC cycle
      @(negedge clk); #1;
      check("exec_op1", alu_operand1, a);
      check("exec_op2", alu_operand2, b);
      check("exec_ctrl", 32'(alu_control), 32'(ill ? 4'd0 : c));
      check("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("exec_rspv", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      // RESP cycles
      @(negedge clk); #1;
      for (int i = 0; i <= hold; i++) begin
         check("resp_valid0", 32'(rsp0_valid), 32'(!own));
         check("resp_valid1", 32'(rsp1_valid), 32'(own));
         check("resp_result", rsp_result, exp_r);
         check("resp_zero", 32'(rsp_zero), 32'(exp_r == 32'd0));
         check("resp_err", 32'(rsp_err), 32'(ill));
         check("resp_ready", 32'({req0_ready, req1_ready}), 32'd0);
         check("resp_alu_hold", alu_operand1, a);
         if (i < hold) begin
            // non-owner ready must not complete the response
            if (own) rsp0_ready = 1'($urandom_range(0, 1));
            else     rsp1_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
         end
      end
      rsp0_ready = !own;
      rsp1_ready = own;
      #1;
      check("handshake_ready", 32'({req0_ready, req1_ready}), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
      req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rspv", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_flags", 32'({rsp_zero, rsp_err}), 32'd0);
      check("rst_alu", alu_operand1 | alu_operand2 | 32'(alu_control), 32'd0);
      rst = 1'b0;

      // Contention from reset: grants alternate 0,1,0,1
      for (int k = 0; k < 4; k++)
         transact(1, 1, 4'd6, 4'd9, 32'd7, 32'd7, 32'hF0, 32'h0F, 0);

      // Single request: 5 + 3
      transact(1, 0, 4'd2, 4'd0, 32'd5, 32'd3, 32'd0, 32'd0, 0);

      // Backpressure: req1 owns (rr_ptr=1), held 4 cycles, then req0 next
      transact(1, 1, 4'd2, 4'd1, 32'd1, 32'd2, 32'h1234, 32'h0F00, 4);
      transact(1, 0, 4'd9, 4'd0, 32'hAA, 32'h55, 32'd0, 32'd0, 0);

      // Shift/compare on requester 1; lone requester repeats without starving
      transact(0, 1, 4'd0, 4'd5, 32'd0, 32'd0, 32'h80000000, 32'd4, 0);
      transact(0, 1, 4'd0, 4'd8, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 1);

      // Illegal op code
      transact(1, 0, 4'hF, 4'd0, 32'd3, 32'd4, 32'd0, 32'd0, 0);

      // Idle with nothing requested
      transact(0, 0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);

      // Reset during EXEC: response discarded, rr_ptr back to 0
      @(negedge clk);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_ctrl = 4'd2; req0_op1 = 32'd9; req0_op2 = 32'd9;
      req1_valid = 1'b0;
      #1;
      check("rstx_grant", 32'(req0_ready), 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rstx_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstx_rspv", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      check("rstx_result", rsp_result, 32'd0);
      check("rstx_alu", alu_operand1 | alu_operand2 | 32'(alu_control), 32'd0);
      model_rr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("rstx_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      end
      transact(1, 1, 4'd1, 4'd1, 32'h10, 32'h01, 32'h20, 32'h02, 0);

      // Randomized traffic against the transaction-level model
      for (int k = 0; k < 40; k++) begin
         bit rv0, rv1;
         rv0 = 1'($urandom_range(0, 1));
         rv1 = 1'($urandom_range(0, 1));
         transact(rv0, rv1,
                  4'($urandom_range(0, OPCHECK ? 15 : 9)),
                  4'($urandom_range(0, OPCHECK ? 15 : 9)),
                  $urandom(), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                  $urandom(), $urandom_range(0, 40),
                  int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
